decode_ctrl: RTL

//  Registered decode stage of the RISC-V core. Accepts instructions from fetch over a

---
 rtl/decode_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/decode_ctrl.sv
// Registered decode stage: valid/ready intake from fetch, imm_sel + control decode,
// one-cycle load-use bubble. Optional feature macro: ILLEGAL_TRAP_EN (illegal port + TRAP).
module decode_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [2:0]  imm_sel,
    output logic        reg_wen,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        alu_src_pc,
    output logic        alu_src_imm,
`ifdef ILLEGAL_TRAP_EN
    output logic        illegal,
`endif
    output logic        load_use_stall
);

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_JLR = 7'b1100111;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_R   = 7'b0110011;

    typedef enum logic [1:0] {
        RUN,
        BUBBLE
`ifdef ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  imm_q, imm_d;
    logic        wen_q, wen_d, rd_q, rd_d, wr_q, wr_d, srcpc_q, srcpc_d, srcimm_q, srcimm_d;
`ifdef ILLEGAL_TRAP_EN
    logic        ill_q, ill_d;
    logic        dec_legal;
`endif

    logic [2:0]  dec_imm;
    logic        dec_wen, dec_rd, dec_wr, dec_pc, dec_src_imm, uses_rs2, rd_nz;
    logic        advance, hazard, in_trap;
    logic [4:0]  id_rd;

    always_comb begin
        dec_imm     = 3'b000;
        dec_wen     = 1'b0;
        dec_rd      = 1'b0;
        dec_wr      = 1'b0;
        dec_pc      = 1'b0;
        dec_src_imm = 1'b0;
        uses_rs2    = 1'b0;
        rd_nz       = |if_inst[11:7];
`ifdef ILLEGAL_TRAP_EN
        dec_legal   = 1'b1;
`endif
        case (if_inst[6:0])
            OP_IMM, OP_JLR: begin dec_wen = rd_nz; dec_src_imm = 1'b1; end
            OP_LD:  begin dec_wen = rd_nz; dec_rd = 1'b1; dec_src_imm = 1'b1; end
            OP_ST:  begin dec_imm = 3'b001; dec_wr = 1'b1; dec_src_imm = 1'b1; uses_rs2 = 1'b1; end
            OP_BR:  begin dec_imm = 3'b010; dec_pc = 1'b1; dec_src_imm = 1'b1; uses_rs2 = 1'b1; end
            OP_LUI: begin dec_imm = 3'b011; dec_wen = rd_nz; dec_src_imm = 1'b1; end
            OP_AUI: begin dec_imm = 3'b011; dec_wen = rd_nz; dec_pc = 1'b1; dec_src_imm = 1'b1; end
            OP_JAL: begin dec_imm = 3'b100; dec_wen = rd_nz; dec_pc = 1'b1; dec_src_imm = 1'b1; end
            OP_R:   begin dec_wen = rd_nz; uses_rs2 = 1'b1; end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                dec_legal = 1'b0;
`endif
            end
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign in_trap = (state_q == TRAP);
`else
    assign in_trap = 1'b0;
`endif

    assign id_rd   = inst_q[11:7];
    assign advance = !valid_q || ex_ready;
    assign hazard  = valid_q && rd_q && (id_rd != 5'd0) && if_valid &&
                     ((if_inst[19:15] == id_rd) || (uses_rs2 && (if_inst[24:20] == id_rd)));

    assign if_ready       = advance && !hazard && !in_trap && !flush;
    assign load_use_stall = advance && hazard && !in_trap && !flush;

    // Default is hold; an emptied slot carries NOP_INST and zero controls but keeps its PC.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        inst_d   = inst_q;
        pc_d     = pc_q;
        imm_d    = imm_q;
        wen_d    = wen_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        srcpc_d  = srcpc_q;
        srcimm_d = srcimm_q;
`ifdef ILLEGAL_TRAP_EN
        ill_d    = ill_q;
`endif
        if (!in_trap && (flush || advance)) begin
            valid_d  = 1'b0;
            inst_d   = NOP_INST;
            imm_d    = 3'b000;
            wen_d    = 1'b0;
            rd_d     = 1'b0;
            wr_d     = 1'b0;
            srcpc_d  = 1'b0;
            srcimm_d = 1'b0;
            state_d  = RUN;
            if (!flush && hazard) begin
                state_d = BUBBLE;
            end else if (!flush && if_valid) begin
                inst_d = if_inst;
                pc_d   = if_pc;
`ifdef ILLEGAL_TRAP_EN
                if (!dec_legal) begin
                    ill_d   = 1'b1;
                    state_d = TRAP;
                end else
`endif
                begin
                    valid_d  = 1'b1;
                    imm_d    = dec_imm;
                    wen_d    = dec_wen;
                    rd_d     = dec_rd;
                    wr_d     = dec_wr;
                    srcpc_d  = dec_pc;
                    srcimm_d = dec_src_imm;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            valid_q  <= 1'b0;
            inst_q   <= NOP_INST;
            pc_q     <= RESET_PC;
            imm_q    <= 3'b000;
            wen_q    <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            srcpc_q  <= 1'b0;
            srcimm_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            ill_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            inst_q   <= inst_d;
            pc_q     <= pc_d;
            imm_q    <= imm_d;
            wen_q    <= wen_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            srcpc_q  <= srcpc_d;
            srcimm_q <= srcimm_d;
`ifdef ILLEGAL_TRAP_EN
            ill_q    <= ill_d;
`endif
        end
    end

    assign id_valid    = valid_q;
    assign id_inst     = inst_q;
    assign id_pc       = pc_q;
    assign imm_sel     = imm_q;
    assign reg_wen     = wen_q;
    assign mem_rd      = rd_q;
    assign mem_wr      = wr_q;
    assign alu_src_pc  = srcpc_q;
    assign alu_src_imm = srcimm_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal     = ill_q;
`endif

endmodule
